// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter
//   Shares one register-read multiplexer between two requesters (A: Avalon
//   side, B: ISA host decoder). A granted read drives the mux address/enable
//   for WAIT_CYCLES cycles, captures the mux output and returns it to the
//   winner together with a one-cycle ack. Round-robin arbitration on
//   contention; A wins the first contention after reset.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   reqA/addrA           requester A request (held until ackA) and address
//   ackA/dataA           A completion pulse and last data returned to A
//   reqB/addrB           requester B request (held until ackB) and address
//   ackB/dataB           B completion pulse and last data returned to B
//   muxAddress/muxEn     mux select and enable (enable only for mapped codes)
//   muxData              mux output
//   busy                 high whenever the sequencer is not idle
//
// WAIT_CYCLES is legal in 1..15.
module reg_read_arbiter #(
  parameter int         WIDTH       = 32,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [2:0] ADDR_REG1   = 3'b001,
  parameter logic [2:0] ADDR_REG2   = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic [2:0]       addrA,
  output logic             ackA,
  output logic [WIDTH-1:0] dataA,
  input  logic             reqB,
  input  logic [2:0]       addrB,
  output logic             ackB,
  output logic [WIDTH-1:0] dataB,
  output logic [2:0]       muxAddress,
  output logic             muxEn,
  input  logic [WIDTH-1:0] muxData,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] count;
  logic [2:0] cur_addr;
  logic       cur_sel;     // 0 = A, 1 = B
  logic       last_grant;  // 0 = A, 1 = B

  logic       grant_b;
  logic [2:0] grant_addr;
  logic       grant_mapped;
  logic       cur_mapped;

  // B wins when it is the only requester, or when both request and A was
  // the last one served.
  always_comb begin
    grant_b      = reqB && (!reqA || !last_grant);
    grant_addr   = grant_b ? addrB : addrA;
    grant_mapped = (grant_addr == ADDR_REG1) || (grant_addr == ADDR_REG2);
    cur_mapped   = (cur_addr == ADDR_REG1) || (cur_addr == ADDR_REG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      cur_addr   <= 3'b000;
      cur_sel    <= 1'b0;
      last_grant <= 1'b1;
      muxEn      <= 1'b0;
      muxAddress <= 3'b000;
      ackA       <= 1'b0;
      ackB       <= 1'b0;
      dataA      <= '0;
      dataB      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ackA <= 1'b0;
          ackB <= 1'b0;
          if (reqA || reqB) begin
            cur_sel    <= grant_b;
            last_grant <= grant_b;
            cur_addr   <= grant_addr;
            // Mux select/enable are registered here so they are already
            // valid during the first SETUP cycle.
            muxAddress <= grant_addr;
            muxEn      <= grant_mapped;
            count      <= 4'(WAIT_CYCLES - 1);
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (count == 4'd0) begin
            // Unmapped addresses never enable the mux, so return zeros
            // rather than whatever is floating on muxData.
            if (cur_sel) begin
              dataB <= cur_mapped ? muxData : '0;
              ackB  <= 1'b1;
            end else begin
              dataA <= cur_mapped ? muxData : '0;
              ackA  <= 1'b1;
            end
            muxEn      <= 1'b0;
            muxAddress <= 3'b000;
            state      <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end

        DONE: begin
          ackA  <= 1'b0;
          ackB  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          muxEn      <= 1'b0;
          muxAddress <= 3'b000;
          ackA       <= 1'b0;
          ackB       <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter: one instance with WAIT_CYCLES=1 and
// one with WAIT_CYCLES=3. Inputs change and outputs are sampled 1ns after
// the rising edge; "cycle N" counts edges after the request is first driven.
module tb_reg_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance with WAIT_CYCLES = 1 ----------------
  logic        reset1, reqA1, reqB1, ackA1, ackB1, muxEn1, busy1;
  logic [2:0]  addrA1, addrB1, muxAddress1;
  logic [31:0] dataA1, dataB1, muxData1;
  logic [31:0] r1_1, r2_1, other_1;

  // Mux model: mapped codes return their register, anything else floats
  // to other_1.
  assign muxData1 = (muxAddress1 == 3'b001) ? r1_1 :
                    (muxAddress1 == 3'b100) ? r2_1 : other_1;

  reg_read_arbiter #(.WIDTH(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1),
    .reqA(reqA1), .addrA(addrA1), .ackA(ackA1), .dataA(dataA1),
    .reqB(reqB1), .addrB(addrB1), .ackB(ackB1), .dataB(dataB1),
    .muxAddress(muxAddress1), .muxEn(muxEn1), .muxData(muxData1),
    .busy(busy1)
  );

  // ---------------- instance with WAIT_CYCLES = 3 ----------------
  logic        reset3, reqA3, reqB3, ackA3, ackB3, muxEn3, busy3;
  logic [2:0]  addrA3, addrB3, muxAddress3;
  logic [31:0] dataA3, dataB3, muxData3;
  logic [31:0] r1_3;

  assign muxData3 = (muxAddress3 == 3'b001) ? r1_3 : 32'h0;

  reg_read_arbiter #(.WIDTH(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset3),
    .reqA(reqA3), .addrA(addrA3), .ackA(ackA3), .dataA(dataA3),
    .reqB(reqB3), .addrB(addrB3), .ackB(ackB3), .dataB(dataB3),
    .muxAddress(muxAddress3), .muxEn(muxEn3), .muxData(muxData3),
    .busy(busy3)
  );

  string order;
  int    acks_seen;
  int    waited;

  initial begin
    reset1 = 1'b1; reqA1 = 1'b0; reqB1 = 1'b0; addrA1 = 3'b000; addrB1 = 3'b000;
    r1_1 = 32'h0; r2_1 = 32'h0; other_1 = 32'h0;
    reset3 = 1'b1; reqA3 = 1'b0; reqB3 = 1'b0; addrA3 = 3'b000; addrB3 = 3'b000;
    r1_3 = 32'h0;
    tick(); tick();
    reset1 = 1'b0; reset3 = 1'b0;
    tick();

    // Reset state
    check("rst_ackA", ackA1, 0);
    check("rst_ackB", ackB1, 0);
    check("rst_dataA", dataA1, 0);
    check("rst_dataB", dataB1, 0);
    check("rst_muxEn", muxEn1, 0);
    check("rst_muxAddress", muxAddress1, 0);
    check("rst_busy", busy1, 0);
    $display("txn reset: checks=%0d errors=%0d", checks, errors);

    // Single A read, WAIT_CYCLES=1
    reqA1 = 1'b1; addrA1 = 3'b001; r1_1 = 32'hDEADBEEF;
    tick();  // cycle 1
    check("single_c1_muxEn", muxEn1, 1);
    check("single_c1_muxAddress", muxAddress1, 3'b001);
    check("single_c1_busy", busy1, 1);
    check("single_c1_ackA", ackA1, 0);
    tick();  // cycle 2
    check("single_c2_ackA", ackA1, 1);
    check("single_c2_dataA", dataA1, 32'hDEADBEEF);
    check("single_c2_dataB", dataB1, 0);
    check("single_c2_busy", busy1, 1);
    check("single_c2_muxEn", muxEn1, 0);
    reqA1 = 1'b0;
    tick();  // cycle 3
    check("single_c3_ackA", ackA1, 0);
    check("single_c3_busy", busy1, 0);
    $display("txn single_A: dataA=%h", dataA1);

    // Contention right after reset: A first, then B
    reset1 = 1'b1; tick(); reset1 = 1'b0;
    check("cont_rst_dataA", dataA1, 0);
    reqA1 = 1'b1; addrA1 = 3'b001; r1_1 = 32'h11111111;
    reqB1 = 1'b1; addrB1 = 3'b100; r2_1 = 32'h22222222;
    tick();  // cycle 1
    check("cont_c1_muxAddress", muxAddress1, 3'b001);
    tick();  // cycle 2
    check("cont_c2_ackA", ackA1, 1);
    check("cont_c2_ackB", ackB1, 0);
    check("cont_c2_dataA", dataA1, 32'h11111111);
    reqA1 = 1'b0;
    tick();  // cycle 3: IDLE, B granted at end
    check("cont_c3_busy", busy1, 0);
    tick();  // cycle 4
    check("cont_c4_muxAddress", muxAddress1, 3'b100);
    check("cont_c4_muxEn", muxEn1, 1);
    tick();  // cycle 5
    check("cont_c5_ackB", ackB1, 1);
    check("cont_c5_dataB", dataB1, 32'h22222222);
    check("cont_c5_dataA", dataA1, 32'h11111111);
    reqB1 = 1'b0;
    tick();
    $display("txn contention: dataA=%h dataB=%h", dataA1, dataB1);

    // Fairness: both held high; B was served last, so A,B,A,B
    order = "";
    acks_seen = 0;
    reqA1 = 1'b1; reqB1 = 1'b1;
    for (int i = 0; i < 40 && acks_seen < 4; i++) begin
      tick();
      if (ackA1 && ackB1) check("fair_both_ack", 1, 0);
      if (ackA1) begin order = {order, "A"}; acks_seen++; end
      if (ackB1) begin order = {order, "B"}; acks_seen++; end
    end
    reqA1 = 1'b0; reqB1 = 1'b0;
    check("fair_ack_count", acks_seen, 4);
    check("fair_order", (order == "ABAB") ? 1 : 0, 1);
    waited = 0;
    while ((busy1 || ackA1 || ackB1) && waited < 10) begin
      tick();
      waited++;
    end
    check("fair_settle_timeout", (waited < 10) ? 1 : 0, 1);
    tick();
    $display("txn fairness: order=%s", order);

    // Unmapped B address: mux stays disabled, zeros returned
    reqB1 = 1'b1; addrB1 = 3'b010; other_1 = 32'hFFFFFFFF;
    tick();  // cycle 1
    check("unmap_c1_muxEn", muxEn1, 0);
    check("unmap_c1_busy", busy1, 1);
    tick();  // cycle 2
    check("unmap_c2_ackB", ackB1, 1);
    check("unmap_c2_dataB", dataB1, 0);
    check("unmap_c2_muxEn", muxEn1, 0);
    check("unmap_c2_dataA", dataA1, 32'h11111111);
    reqB1 = 1'b0;
    tick();
    check("unmap_c3_ackB", ackB1, 0);
    $display("txn unmapped_B: dataB=%h", dataB1);

    // Reset mid-operation, WAIT_CYCLES=3
    reqA3 = 1'b1; addrA3 = 3'b001; r1_3 = 32'h12345678;
    tick();  // cycle 1
    check("rmid_c1_muxEn", muxEn3, 1);
    tick();  // cycle 2
    check("rmid_c2_busy", busy3, 1);
    reset3 = 1'b1;
    tick();  // cycle 3
    reset3 = 1'b0; reqA3 = 1'b0;
    check("rmid_c3_busy", busy3, 0);
    check("rmid_c3_muxEn", muxEn3, 0);
    check("rmid_c3_ackA", ackA3, 0);
    check("rmid_c3_dataA", dataA3, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ackA3) check("rmid_late_ackA", ackA3, 0);
    end
    $display("txn reset_mid_op: busy=%0d dataA=%h", busy3, dataA3);

    // Settle timing, WAIT_CYCLES=3: data sampled at end of cycle 3
    reqA3 = 1'b1; addrA3 = 3'b001; r1_3 = 32'hAAAA0000;
    tick();  // cycle 1
    check("settle_c1_muxEn", muxEn3, 1);
    tick();  // cycle 2
    r1_3 = 32'h0000BBBB;
    addrA3 = 3'b100;  // ignored after grant
    check("settle_c2_ackA", ackA3, 0);
    tick();  // cycle 3
    check("settle_c3_ackA", ackA3, 0);
    check("settle_c3_muxAddress", muxAddress3, 3'b001);
    tick();  // cycle 4
    check("settle_c4_ackA", ackA3, 1);
    check("settle_c4_dataA", dataA3, 32'h0000BBBB);
    check("settle_c4_muxEn", muxEn3, 0);
    reqA3 = 1'b0;
    tick();
    check("settle_c5_ackA", ackA3, 0);
    $display("txn settle: dataA=%h", dataA3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_read_arbiter.md
Name: reg_read_arbiter

Overview:
Sequences and shares the register-read multiplexer between two requesters: A is the QSYS/Avalon side, and B is the ISA host-side decoder. The block owns the mux `address`/`en` inputs, holds them for a programmable settle time, captures the mux output, and returns it to the winning requester with a one-cycle ack pulse. It uses round-robin arbitration, so neither side can starve the other.

Parameters:
WIDTH, 32, data width of the register file and mux output
WAIT_CYCLES, 1, cycles the mux select/enable is held before sampling; legal range 1..15
ADDR_REG1, 3'b001, select code for register 1
ADDR_REG2, 3'b100, select code for register 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
reqA  input  1  requester A read request; held until ackA
addrA  input  3  requester A register address
ackA  output  1  one-cycle pulse: dataA updated
dataA  output  WIDTH  last read data returned to A
reqB  input  1  requester B read request; held until ackB
addrB  input  3  requester B register address
ackB  output  1  one-cycle pulse: dataB updated
dataB  output  WIDTH  last read data returned to B
muxAddress  output  3  drives mux address input
muxEn  output  1  drives mux enable input
muxData  input  WIDTH  mux output
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, `clk`. Reset (`reset`) is synchronous and active-high.
- Reset values: state=IDLE, muxEn=0, muxAddress=3'b000, ackA=ackB=0, dataA=dataB=0, busy=0, lastGrant=B (so A wins the first contention).
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, DONE.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one req high: grant that requester.
- IDLE, both req high: grant the requester not equal to lastGrant. lastGrant is updated on grant.
- On grant:
  - latch the granted address into curAddr and the granted side into curSel;
  - load the counter with WAIT_CYCLES-1;
  - go to SETUP.
- SETUP:
  - muxAddress=curAddr throughout.
  - muxEn=1 only if curAddr is ADDR_REG1 or ADDR_REG2; otherwise muxEn=0 (unmapped).
  - Counter decrements each cycle.
  - When the counter reaches 0, at that edge: capture into data[curSel] (muxData if mapped, else all zeros), set ack[curSel]=1, go to DONE.
- DONE (exactly one cycle):
  - ack[curSel]=1, muxEn=0, muxAddress=3'b000.
  - Requests are ignored.
  - Next state is IDLE; ack returns to 0.
- Latency: request seen in IDLE on cycle 0.
  - SETUP occupies cycles 1..WAIT_CYCLES.
  - ack and data are valid in cycle WAIT_CYCLES+1.
  - Earliest next grant is evaluated in cycle WAIT_CYCLES+2.
- Throughput: one read per WAIT_CYCLES+2 cycles.
- Requester protocol:
  - Hold req and addr stable until ack is seen.
  - Drop req in the cycle after ack; req must be low by the next IDLE evaluation.
  - A req still high in IDLE is treated as a new request.
- Address change after grant is ignored, because the latched curAddr is used.
- req dropped during SETUP: the transaction still completes and ack still pulses.
- dataA/dataB hold their value until that requester's next completion; the other side's data is never touched.
- Reset mid-transaction: return to IDLE immediately, no ack issued, data registers cleared to 0, muxEn=0.
- muxEn is never high outside SETUP, so the mux is tri-stated in IDLE and DONE.

Test Plan:
- Single A read (WAIT_CYCLES=1): reqA=1, addrA=3'b001, muxData=32'hDEADBEEF → muxEn=1 in cycle 1; ackA=1 and dataA=32'hDEADBEEF in cycle 2; dataB stays 0; busy high in cycles 1–2.
- Contention: reqA and reqB both rise in the same cycle after reset, addrA=3'b001 (data 32'h11111111), addrB=3'b100 (data 32'h22222222) → A served first (ackA in cycle 2); B granted in cycle 3 and ackB in cycle 5 with dataB=32'h22222222.
- Fairness: reqA held continuously (re-requesting) while reqB pending → grants alternate A,B,A,B; no requester waits more than one transaction.
- Unmapped address: reqB=1, addrB=3'b010, muxData driven 32'hFFFFFFFF → muxEn stays 0 throughout; ackB pulses in cycle 2; dataB=32'h00000000.
- Reset mid-op (WAIT_CYCLES=3): reqA granted; reset asserted in cycle 2 → cycle 3 shows state IDLE, muxEn=0, ackA never pulses, dataA=0.
- Settle timing (WAIT_CYCLES=3): muxData changes from 32'hAAAA0000 to 32'h0000BBBB in cycle 2 → dataA captures 32'h0000BBBB (sampled at the end of cycle 3); ackA in cycle 4.
